memory_access: RTL and testbench
================================

MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 64: data memory words (20 bit), address = aluResult[5:0].
REQ-002 The block SHALL have parameter MEM_LATENCY, default 2, legal 1..3: wait cycles per memory access.
REQ-003 The block SHALL have port clock  in  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  in  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port inValid  in  1  execute stage presents a valid instruction.
REQ-006 The block SHALL have port instruction  in  20  propagated instruction; opcode [19:16], rd [15:11].
REQ-007 The block SHALL have port aluResult  in  20  ALU result; data for ALU ops, address for LW/SW.
REQ-008 The block SHALL have port storeData  in  20  register read data 2; SW write data.
REQ-009 The block SHALL have port ulaZero  in  1  ALU equality flag.
REQ-010 The block SHALL have port stall  out  1  upstream must hold its inputs; inValid ignored.
REQ-011 The block SHALL have port outValid  out  1  one-cycle pulse per retired instruction.
REQ-012 The block SHALL have port wbInstruction  out  20  retired instruction.
REQ-013 The block SHALL have port wbData  out  20  write-back data.
REQ-014 The block SHALL have port wbRd  out  5  write-back register = instruction[15:11].
REQ-015 The block SHALL have port wbRegWrite  out  1  register-file write enable.
REQ-016 The block SHALL have port branchTaken  out  1  BEQ with ulaZero=1 retired.

Function
REQ-017 Opcodes SHALL be: 0x0 NOP, 0x1 LW, 0x2 SW, 0x3 BEQ, 0x4-0x7 ALU ops; all others treated as NOP.
REQ-018 The block SHALL have a two-state machine: IDLE and WAIT; stall SHALL equal (state==WAIT), decoded from the state register only.
REQ-019 In IDLE with inValid=1, the block SHALL capture instruction, aluResult, storeData and ulaZero into the EX/MEM register on the clock edge.
REQ-020 A non-memory op captured at edge N SHALL retire at edge N: outputs valid with outValid=1 in cycle N+1 (latency 1), state stays IDLE.
REQ-021 An LW/SW captured at edge N SHALL enter WAIT with counter=MEM_LATENCY-1; the counter SHALL decrement once per cycle in WAIT.
REQ-022 At the WAIT edge where counter==0, the block SHALL perform the access (SW: mem[addr]<=storeData; LW: wbData<=mem[addr]), retire (outValid=1 next cycle) and return to IDLE.
REQ-023 For an LW/SW, stall SHALL be high for exactly MEM_LATENCY cycles, and outValid SHALL rise MEM_LATENCY+1 cycles after capture.
REQ-024 In WAIT, inValid and all data inputs SHALL be ignored; the captured copies are used.
REQ-025 wbData SHALL be aluResult for ALU ops, memory word for LW, and the captured aluResult for SW/BEQ/NOP.
REQ-026 wbRegWrite SHALL be 1 only with outValid=1, for LW or ALU ops with rd!=0; rd==0 SHALL never be written.
REQ-027 branchTaken SHALL be 1 only with outValid=1 for BEQ whose captured ulaZero=1.
REQ-028 outValid, wbRegWrite and branchTaken SHALL be single-cycle pulses; wbInstruction, wbData and wbRd SHALL hold between retirements.
REQ-029 Address bits aluResult[19:6] SHALL be ignored (address wraps modulo 64).
REQ-030 An SW followed immediately by an LW to the same address SHALL return the stored value.
REQ-031 An instruction presented in the first IDLE cycle after WAIT SHALL be accepted (no bubble beyond stall).

Reset
REQ-032 With reset low, state SHALL be IDLE; counter, stall, outValid, wbRegWrite and branchTaken SHALL be 0; wbInstruction, wbData and wbRd SHALL be 0; all memory words SHALL be 0.
REQ-033 Reset asserted during WAIT SHALL abort the access with no memory write and no retirement.
REQ-034 After reset is released, the first rising edge SHALL be able to accept an instruction.

Verification
REQ-035 ALU op 0x4, rd=3, aluResult=0x00002, inValid=1 in one cycle -> next cycle: outValid=1, wbRegWrite=1, wbRd=3, wbData=0x00002, stall=0.
REQ-036 SW addr 0x00045, storeData=0xABCDE, then LW addr 0x00005, rd=7 -> stall high 2 cycles per op, LW wbData=0xABCDE (wrap), wbRegWrite=1 only on LW.
REQ-037 BEQ with ulaZero=1, then BEQ with ulaZero=0 -> branchTaken pulses once, wbRegWrite=0 for both.
REQ-038 During a stall, toggle inValid and change aluResult -> the captured op completes with its original values, and the new inputs are not accepted.
REQ-039 Reset asserted mid-WAIT of SW 0x11111 to addr 9, then LW addr 9 -> wbData=0x00000, and no outValid pulse before the LW retires.
REQ-040 ALU op with rd=0 -> outValid=1, wbRegWrite=0.

Source files
------------

// File: rtl/memory_access.sv
// Memory-access pipeline stage: single-cycle retirement of ALU/branch/NOP ops,
// multi-cycle LW/SW against a small resettable data memory.
module memory_access #(
  parameter int MEM_DEPTH   = 64,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inValid,
  input  logic [19:0] instruction,
  input  logic [19:0] aluResult,
  input  logic [19:0] storeData,
  input  logic        ulaZero,
  output logic        stall,
  output logic        outValid,
  output logic [19:0] wbInstruction,
  output logic [19:0] wbData,
  output logic [4:0]  wbRd,
  output logic        wbRegWrite,
  output logic        branchTaken
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [1:0] CNT_INIT = 2'(MEM_LATENCY - 1);

  localparam logic [3:0] OP_LW  = 4'h1;
  localparam logic [3:0] OP_SW  = 4'h2;
  localparam logic [3:0] OP_BEQ = 4'h3;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state;
  logic [1:0]  counter;
  logic [19:0] exInstr;
  logic [19:0] exAlu;
  logic [19:0] exStore;
  logic        exZero;
  logic [19:0] mem [MEM_DEPTH];

  logic [3:0]    inOp, exOp;
  logic [4:0]    inRd, exRd;
  logic [AW-1:0] exAddr;

  assign inOp   = instruction[19:16];
  assign inRd   = instruction[15:11];
  assign exOp   = exInstr[19:16];
  assign exRd   = exInstr[15:11];
  assign exAddr = exAlu[AW-1:0];

  assign stall = (state == WAIT);

  function automatic logic isAlu(input logic [3:0] op);
    return op[3:2] == 2'b01;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      counter       <= '0;
      outValid      <= 1'b0;
      wbRegWrite    <= 1'b0;
      branchTaken   <= 1'b0;
      wbInstruction <= '0;
      wbData        <= '0;
      wbRd          <= '0;
      exInstr       <= '0;
      exAlu         <= '0;
      exStore       <= '0;
      exZero        <= 1'b0;
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      outValid    <= 1'b0;
      wbRegWrite  <= 1'b0;
      branchTaken <= 1'b0;
      case (state)
        IDLE: begin
          if (inValid) begin
            exInstr <= instruction;
            exAlu   <= aluResult;
            exStore <= storeData;
            exZero  <= ulaZero;
            if (inOp == OP_LW || inOp == OP_SW) begin
              state   <= WAIT;
              counter <= CNT_INIT;
            end else begin
              // Non-memory ops retire straight from the live inputs on the capture edge.
              outValid      <= 1'b1;
              wbInstruction <= instruction;
              wbData        <= aluResult;
              wbRd          <= inRd;
              wbRegWrite    <= isAlu(inOp) && (inRd != '0);
              branchTaken   <= (inOp == OP_BEQ) && ulaZero;
            end
          end
        end
        WAIT: begin
          if (counter == '0) begin
            state         <= IDLE;
            outValid      <= 1'b1;
            wbInstruction <= exInstr;
            wbRd          <= exRd;
            wbRegWrite    <= (exOp == OP_LW || isAlu(exOp)) && (exRd != '0);
            branchTaken   <= (exOp == OP_BEQ) && exZero;
            if (exOp == OP_LW) begin
              wbData <= mem[exAddr];
            end else begin
              wbData <= exAlu;
              if (exOp == OP_SW) mem[exAddr] <= exStore;
            end
          end else begin
            counter <= counter - 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Randomized scoreboard bench for memory_access: a driver pushes expected
// retirements computed from an array-based memory model; a monitor pops them.
module tb_memory_access;

  localparam int LAT = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        inValid = 1'b0;
  logic [19:0] instruction = '0;
  logic [19:0] aluResult = '0;
  logic [19:0] storeData = '0;
  logic        ulaZero = 1'b0;
  logic        stall, outValid, wbRegWrite, branchTaken;
  logic [19:0] wbInstruction, wbData;
  logic [4:0]  wbRd;

  memory_access #(.MEM_DEPTH(64), .MEM_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .inValid(inValid), .instruction(instruction),
    .aluResult(aluResult), .storeData(storeData), .ulaZero(ulaZero),
    .stall(stall), .outValid(outValid), .wbInstruction(wbInstruction),
    .wbData(wbData), .wbRd(wbRd), .wbRegWrite(wbRegWrite), .branchTaken(branchTaken)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [19:0] instr;
    logic [19:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        br;
    int          retireEdge;
  } exp_t;

  exp_t        q[$];
  logic [19:0] model [64];
  logic [19:0] lastInstr = '0, lastData = '0;
  logic [4:0]  lastRd = '0;
  int          edges = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clock) edges++;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at t=%0t", nm, got, exp, $time);
    end
  endtask

  // Monitor: pops on every retirement, otherwise checks pulses low and data held.
  always @(negedge clock) begin
    if (reset) begin
      if (outValid) begin
        if (q.size() == 0) begin
          chk("unexpected_retire", 32'(outValid), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("wbInstruction", 32'(wbInstruction), 32'(e.instr));
          chk("wbData", 32'(wbData), 32'(e.data));
          chk("wbRd", 32'(wbRd), 32'(e.rd));
          chk("wbRegWrite", 32'(wbRegWrite), 32'(e.rw));
          chk("branchTaken", 32'(branchTaken), 32'(e.br));
          chk("retire_edge", 32'(edges), 32'(e.retireEdge));
          lastInstr = e.instr;
          lastData  = e.data;
          lastRd    = e.rd;
        end
      end else begin
        chk("regwrite_pulse", 32'(wbRegWrite), 32'd0);
        chk("branch_pulse", 32'(branchTaken), 32'd0);
        chk("hold_instr", 32'(wbInstruction), 32'(lastInstr));
        chk("hold_data", 32'(wbData), 32'(lastData));
        chk("hold_rd", 32'(wbRd), 32'(lastRd));
      end
    end
  end

  task automatic modelReset();
    q.delete();
    for (int i = 0; i < 64; i++) model[i] = '0;
    lastInstr = '0;
    lastData  = '0;
    lastRd    = '0;
  endtask

  task automatic checkResetOutputs();
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_outValid", 32'(outValid), 32'd0);
    chk("rst_regWrite", 32'(wbRegWrite), 32'd0);
    chk("rst_branch", 32'(branchTaken), 32'd0);
    chk("rst_instr", 32'(wbInstruction), 32'd0);
    chk("rst_data", 32'(wbData), 32'd0);
    chk("rst_rd", 32'(wbRd), 32'd0);
  endtask

  // Called at a negedge with stall low; returns at a negedge with stall low.
  task automatic issue(input logic [3:0] op, input logic [4:0] rd, input logic [19:0] alu,
                       input logic [19:0] sdata, input logic z);
    exp_t e;
    logic isMem;
    logic [19:0] instr;
    instr = {op, rd, 11'($urandom)};
    isMem = (op == 4'h1) || (op == 4'h2);
    e.instr = instr;
    e.rd    = rd;
    e.data  = alu;
    e.rw    = 1'b0;
    e.br    = (op == 4'h3) && z;
    if (op == 4'h1) begin
      e.data = model[alu % 64];
      e.rw   = (rd != 0);
    end else if (op == 4'h2) begin
      model[alu % 64] = sdata;
    end else if (op >= 4'h4 && op <= 4'h7) begin
      e.rw = (rd != 0);
    end
    e.retireEdge = edges + 1 + (isMem ? LAT : 0);
    q.push_back(e);
    inValid = 1'b1; instruction = instr; aluResult = alu; storeData = sdata; ulaZero = z;
    @(negedge clock);
    if (isMem) begin
      for (int k = 0; k < LAT; k++) begin
        chk("stall_high", 32'(stall), 32'd1);
        inValid = 1'($urandom); instruction = 20'($urandom);
        aluResult = 20'($urandom); storeData = 20'($urandom); ulaZero = 1'($urandom);
        @(negedge clock);
      end
    end
    chk("stall_low", 32'(stall), 32'd0);
    inValid = 1'b0;
  endtask

  initial begin
    modelReset();
    #12;
    checkResetOutputs();
    @(negedge clock);
    reset = 1'b1;

    issue(4'h4, 5'd3, 20'h00002, 20'h0, 1'b0);
    issue(4'h2, 5'd0, 20'h00045, 20'hABCDE, 1'b0);
    issue(4'h1, 5'd7, 20'h00005, 20'h0, 1'b0);
    issue(4'h3, 5'd1, 20'h00010, 20'h0, 1'b1);
    issue(4'h3, 5'd2, 20'h00011, 20'h0, 1'b0);
    issue(4'h5, 5'd0, 20'h12345, 20'h0, 1'b0);
    issue(4'h0, 5'd4, 20'h0BEEF, 20'h0, 1'b1);
    issue(4'hA, 5'd5, 20'h0CAFE, 20'h0, 1'b0);

    // Abort a store mid-wait with reset; the later load must read zero.
    @(negedge clock);
    inValid = 1'b1; instruction = {4'h2, 5'd0, 11'd0}; aluResult = 20'd9;
    storeData = 20'h11111;
    @(negedge clock);
    inValid = 1'b0;
    chk("abort_in_wait", 32'(stall), 32'd1);
    #1 reset = 1'b0;
    modelReset();
    #1 checkResetOutputs();
    @(negedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    issue(4'h1, 5'd9, 20'h00009, 20'h0, 1'b0);

    for (int n = 0; n < 250; n++) begin
      logic [3:0]  op;
      logic [4:0]  rd;
      logic [19:0] alu;
      op  = 4'($urandom_range(0, 15));
      if (n % 3 == 0) op = 4'($urandom_range(1, 2));
      rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      alu = {14'($urandom), 6'($urandom_range(0, 7))};
      issue(op, rd, alu, 20'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) @(negedge clock);
    end

    for (int w = 0; w < 20 && q.size() != 0; w++) @(negedge clock);
    chk("drain", 32'(q.size()), 32'd0);
    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
